button_events: RTL and testbench

- Consumes the clean, debounced button level produced by the debounce stage and turns it into discrete single-cycle events for the stopwatch control FSM.
- Events: press, release (tagged short or long), a one-shot long-press, and auto-repeat while held.
- Sits between the debounce instances and the start/stop/lap/reset control logic; one instance per button.

---
 rtl/stopwatch_pkg.sv | 16 +
 rtl/ms_tick.sv | 29 ++
 rtl/button_events.sv | 116 +++++++++++
 tb/tb_button_events.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types for the stopwatch button path: hold-state encoding and a
// millisecond-to-cycle helper.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      HELD      = 2'd1,
      HELD_LONG = 2'd2
   } btn_state_e;

   function automatic int unsigned ms_to_cycles(input int unsigned ms,
                                                input int unsigned khz);
      return ms * khz;
   endfunction

endpackage

// File: rtl/ms_tick.sv
// Restartable millisecond prescaler: tick pulses once every CLK_FREQ_KHZ
// cycles, counted from the last cycle in which restart was high.
module ms_tick #(
   parameter int unsigned CLK_FREQ_KHZ = 100_000
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);

   localparam int unsigned W = (CLK_FREQ_KHZ > 1) ? $clog2(CLK_FREQ_KHZ) : 1;
   localparam logic [W-1:0] LAST = W'(CLK_FREQ_KHZ - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || restart)
         cnt <= '0;
      else if (cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   // Suppressed while restarting so a stale phase can never leak into a new hold.
   assign tick = (cnt == LAST) && !restart;

endmodule

// File: rtl/button_events.sv
// Turns a debounced button level into press / release / long-press /
// auto-repeat pulses for the stopwatch control FSM.
module button_events
   import stopwatch_pkg::*;
#(
   parameter int unsigned CLK_FREQ_KHZ     = 100_000,
   parameter int unsigned LONG_MS          = 1000,
   parameter int unsigned REPEAT_DELAY_MS  = 500,
   parameter int unsigned REPEAT_PERIOD_MS = 100
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press,
   output logic release_evt,
   output logic was_long,
   output logic long_press,
   output logic repeat_evt,
   output logic held
);

   localparam int unsigned MSW     = $clog2(LONG_MS + 1);
   localparam int unsigned RPT_MAX = (REPEAT_DELAY_MS > REPEAT_PERIOD_MS) ?
                                     REPEAT_DELAY_MS : REPEAT_PERIOD_MS;
   localparam int unsigned RW      = $clog2(RPT_MAX + 1);

   localparam logic [MSW-1:0] LONG_LAST   = MSW'(LONG_MS - 1);
   localparam logic [MSW-1:0] LONG_SAT    = MSW'(LONG_MS);
   localparam logic [RW-1:0]  DELAY_LOAD  = RW'(REPEAT_DELAY_MS - 1);
   localparam logic [RW-1:0]  PERIOD_LOAD = RW'(REPEAT_PERIOD_MS - 1);

   btn_state_e     state;
   logic           btn_q;
   logic           tick;
   logic           restart;
   logic [MSW-1:0] ms_cnt;
   logic [RW-1:0]  rpt_cnt;

   // The prescaler sits at zero whenever idle, so the press cycle is phase 0.
   assign restart = (state == IDLE);

   ms_tick #(
      .CLK_FREQ_KHZ(CLK_FREQ_KHZ)
   ) u_ms_tick (
      .clk    (clk),
      .rst    (rst),
      .restart(restart),
      .tick   (tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         // btn_q tracks btn through reset so a button held at reset exit is not a press.
         state       <= IDLE;
         btn_q       <= btn;
         ms_cnt      <= '0;
         rpt_cnt     <= '0;
         press       <= 1'b0;
         release_evt <= 1'b0;
         was_long    <= 1'b0;
         long_press  <= 1'b0;
         repeat_evt  <= 1'b0;
         held        <= 1'b0;
      end else begin
         btn_q       <= btn;
         // NOTE: pulses default low here and are overridden below; with <= the
         // last assignment in the block wins, giving clean one-cycle strobes.
         press       <= 1'b0;
         release_evt <= 1'b0;
         was_long    <= 1'b0;
         long_press  <= 1'b0;
         repeat_evt  <= 1'b0;

         case (state)
            IDLE: begin
               if (btn && !btn_q) begin
                  state   <= HELD;
                  press   <= 1'b1;
                  held    <= 1'b1;
                  ms_cnt  <= '0;
                  rpt_cnt <= DELAY_LOAD;
               end
            end

            HELD, HELD_LONG: begin
               // Release takes priority over any long-press or repeat due now.
               if (!btn) begin
                  state       <= IDLE;
                  held        <= 1'b0;
                  release_evt <= 1'b1;
                  was_long    <= (state == HELD_LONG);
               end else if (tick) begin
                  if (ms_cnt != LONG_SAT)
                     ms_cnt <= ms_cnt + 1'b1;
                  if (state == HELD && ms_cnt == LONG_LAST) begin
                     state      <= HELD_LONG;
                     long_press <= 1'b1;
                  end
                  if (rpt_cnt == '0) begin
                     repeat_evt <= 1'b1;
                     rpt_cnt    <= PERIOD_LOAD;
                  end else begin
                     rpt_cnt <= rpt_cnt - 1'b1;
                  end
               end
            end

            default: begin
               state <= IDLE;
               held  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_button_events.sv
// Directed bench for button_events with a 4-cycle millisecond so every
// long-press / repeat boundary is reachable in a few hundred cycles.
module tb_button_events;
   import stopwatch_pkg::*;

   localparam int unsigned KHZ     = 4;
   localparam int          RPT_GAP = int'(ms_to_cycles(5, KHZ));

   logic clk;
   logic rst;
   logic btn;
   logic press;
   logic release_evt;
   logic was_long;
   logic long_press;
   logic repeat_evt;
   logic held;

   int checks   = 0;
   int failures = 0;

   // Observed events of one hold, times relative to the press cycle P.
   typedef struct {
      int press_n;
      int press_at;
      int rel_n;
      int rel_at;
      int wl;
      int wl_stray;
      int long_n;
      int long_at;
      int rpt_n;
      int rpt_first;
      int gap_err;
      int held_n;
   } obs_t;

   // Hold length in cycles plus hand-computed expected events.
   typedef struct {
      int n;
      int rel_at;
      int wl;
      int long_n;
      int long_at;
      int rpt_n;
      int rpt_first;
   } vec_t;

   button_events #(
      .CLK_FREQ_KHZ    (KHZ),
      .LONG_MS         (10),
      .REPEAT_DELAY_MS (5),
      .REPEAT_PERIOD_MS(5)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .btn        (btn),
      .press      (press),
      .release_evt(release_evt),
      .was_long   (was_long),
      .long_press (long_press),
      .repeat_evt (repeat_evt),
      .held       (held)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act != exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Drives btn high for n sampled cycles, then low, observing n+tail cycles.
   task automatic run_hold(input int n, input int tail, output obs_t o);
      int last_rpt;
      o = '{default: 0};
      o.press_at  = -1;
      o.rel_at    = -1;
      o.long_at   = -1;
      o.rpt_first = -1;
      last_rpt    = -1;
      btn = 1'b1;
      for (int i = 1; i <= n + tail; i++) begin
         @(posedge clk);
         #1;
         if (press) begin
            o.press_n  = o.press_n + 1;
            o.press_at = i - 1;
         end
         if (release_evt) begin
            o.rel_n  = o.rel_n + 1;
            o.rel_at = i - 1;
            o.wl     = int'(was_long);
         end else if (was_long) begin
            o.wl_stray = o.wl_stray + 1;
         end
         if (long_press) begin
            o.long_n  = o.long_n + 1;
            o.long_at = i - 1;
         end
         if (repeat_evt) begin
            o.rpt_n = o.rpt_n + 1;
            if (o.rpt_first < 0)
               o.rpt_first = i - 1;
            else if (i - 1 - last_rpt != RPT_GAP)
               o.gap_err = o.gap_err + 1;
            last_rpt = i - 1;
         end
         if (held)
            o.held_n = o.held_n + 1;
         if (i == n)
            btn = 1'b0;
      end
   endtask

   task automatic check_obs(input string tag, input vec_t v, input obs_t o);
      check({tag, ".press_n"},  o.press_n,  1);
      check({tag, ".press_at"}, o.press_at, 0);
      check({tag, ".rel_n"},    o.rel_n,    1);
      check({tag, ".rel_at"},   o.rel_at,   v.rel_at);
      check({tag, ".was_long"}, o.wl,       v.wl);
      check({tag, ".wl_stray"}, o.wl_stray, 0);
      check({tag, ".long_n"},   o.long_n,   v.long_n);
      if (v.long_n > 0)
         check({tag, ".long_at"}, o.long_at, v.long_at);
      check({tag, ".rpt_n"},    o.rpt_n,    v.rpt_n);
      if (v.rpt_n > 0)
         check({tag, ".rpt_first"}, o.rpt_first, v.rpt_first);
      check({tag, ".rpt_gap"},  o.gap_err,  0);
      check({tag, ".held_n"},   o.held_n,   v.n);
   endtask

   initial begin
      vec_t vecs[8];
      obs_t o;
      int   post_any;
      int   pre_press;

      //             n     rel   wl lng l_at rpt r_first
      vecs[0] = '{  12,   12,   0, 0,  0,   0,  0 };   // short press
      vecs[1] = '{  50,   50,   1, 1, 40,   2, 20 };   // long hold
      vecs[2] = '{  40,   40,   0, 0,  0,   1, 20 };   // release beats long+repeat
      vecs[3] = '{  20,   20,   0, 0,  0,   0,  0 };   // release beats first repeat
      vecs[4] = '{  21,   21,   0, 0,  0,   1, 20 };
      vecs[5] = '{  41,   41,   1, 1, 40,   2, 20 };
      vecs[6] = '{   1,    1,   0, 0,  0,   0,  0 };   // single-cycle press
      vecs[7] = '{1000, 1000,   1, 1, 40,  49, 20 };   // saturation

      rst = 1'b1;
      btn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs",
            int'({press, release_evt, was_long, long_press, repeat_evt, held}), 0);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      for (int k = 0; k < 8; k++) begin
         run_hold(vecs[k].n, 4, o);
         check_obs($sformatf("vec%0d", k), vecs[k], o);
      end

      // Back-to-back: 30-cycle hold leaves the prescaler mid-phase, then a
      // new press two cycles after the release pulse.
      run_hold(30, 2, o);
      check("b2b_first.rel_at", o.rel_at, 30);
      run_hold(50, 4, o);
      check_obs("b2b_second", vecs[1], o);

      // Reset while held, button kept down through and after reset.
      post_any  = 0;
      pre_press = 0;
      btn = 1'b1;
      for (int i = 1; i <= 80; i++) begin
         @(posedge clk);
         #1;
         if (i >= 11) begin
            if (press || release_evt || was_long || long_press || repeat_evt || held)
               post_any = post_any + 1;
         end else if (press) begin
            pre_press = pre_press + 1;
         end
         if (i == 10) rst = 1'b1;
         if (i == 11) rst = 1'b0;
         if (i == 70) btn = 1'b0;
      end
      check("rst_hold.pre_press", pre_press, 1);
      check("rst_hold.post_events", post_any, 0);

      // Normal operation resumes after the suppressed hold.
      run_hold(3, 4, o);
      check("after_rst.press_n", o.press_n, 1);
      check("after_rst.rel_at", o.rel_at, 3);
      check("after_rst.held_n", o.held_n, 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
